// File: rtl/r_chan_push_pkg.sv
// Shared AXI R-channel definitions: field widths, R-word layout, RESP codes,
// push-side FSM states and the burst-tracker entry type.
package r_chan_push_pkg;

   localparam int ID_W    = 4;
   localparam int LEN_W   = 4;
   localparam int DATA_W  = 32;
   localparam int RESP_W  = 2;
   localparam int RWORD_W = ID_W + DATA_W + RESP_W + 1;

   localparam int RLAST_BIT = 0;
   localparam int RRESP_LSB = RLAST_BIT + 1;
   localparam int RDATA_LSB = RRESP_LSB + RESP_W;
   localparam int RID_LSB   = RDATA_LSB + DATA_W;

   localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
   localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DRAIN = 2'd2
   } r_state_e;

   typedef struct packed {
      logic [ID_W-1:0]  id;
      logic [LEN_W-1:0] len;
   } trk_entry_t;

   function automatic logic [RWORD_W-1:0] pack_rword(
      input logic [ID_W-1:0]   id,
      input logic [DATA_W-1:0] data,
      input logic [RESP_W-1:0] resp,
      input logic              last
   );
      logic [RWORD_W-1:0] w;
      w                       = '0;
      w[RID_LSB +: ID_W]      = id;
      w[RDATA_LSB +: DATA_W]  = data;
      w[RRESP_LSB +: RESP_W]  = resp;
      w[RLAST_BIT]            = last;
      return w;
   endfunction

endpackage

// File: rtl/r_burst_tracker.sv
// In-order queue of outstanding read bursts {id, len}; the head is always
// entry 0, so a pop shifts the queue down one slot.
module r_burst_tracker
   import r_chan_push_pkg::*;
#(
   parameter int TRK_DEPTH = 2
) (
   input  logic       w_clk,
   input  logic       w_rst,
   input  logic       push_i,
   input  trk_entry_t entry_i,
   input  logic       pop_i,
   output trk_entry_t head_o,
   output logic       empty_o,
   output logic       full_o
);

   localparam int CNT_W = $clog2(TRK_DEPTH + 1);

   trk_entry_t       mem_q [TRK_DEPTH];
   trk_entry_t       mem_d [TRK_DEPTH];
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] wr_idx;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CNT_W'(TRK_DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[0];

   // A push while full is only taken when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      mem_d  = mem_q;
      wr_idx = do_pop ? (count_q - CNT_W'(1)) : count_q;
      if (do_pop) begin
         for (int i = 0; i < TRK_DEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
      end
      if (do_push) begin
         for (int i = 0; i < TRK_DEPTH; i++) begin
            if (CNT_W'(i) == wr_idx) mem_d[i] = entry_i;
         end
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge w_clk) begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      if (w_rst) begin
         count_q <= '0;
         // NOTE: entries are cleared as well; the array is tiny and a clean head keeps rid deterministic.
         mem_q   <= '{default: '0};
      end else begin
         count_q <= count_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: rtl/r_chan_push.sv
// Slave-side R-channel push: checks beats against tracked AR lengths, tags them
// with the tracked ID and feeds the async R FIFO through an output+skid buffer.
module r_chan_push
   import r_chan_push_pkg::*;
#(
   parameter int TRK_DEPTH = 2
) (
   input  logic               w_clk,
   input  logic               w_rst,
   input  logic               ar_fire,
   input  logic [ID_W-1:0]    ar_id,
   input  logic [LEN_W-1:0]   ar_len,
   output logic               trk_full,
   input  logic               s_rvalid,
   input  logic [ID_W-1:0]    s_rid,
   input  logic [DATA_W-1:0]  s_rdata,
   input  logic [RESP_W-1:0]  s_rresp,
   input  logic               s_rlast,
   output logic               s_rready,
   output logic               fifo_push,
   output logic [RWORD_W-1:0] fifo_data,
   input  logic               fifo_full,
   output logic               len_err
);

   r_state_e           state_q, state_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic [RWORD_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
   logic               s_rready_q, s_rready_d, len_err_q, len_err_d;

   trk_entry_t         ar_entry, trk_head;
   logic               trk_empty, trk_pop;
   logic               r_accept, last_exp, final_beat, len_viol, beat_valid;
   logic [RWORD_W-1:0] beat_word;

   // The slave's RID is not trusted; the tracked AR ID is used instead.
   logic               unused_rid;
   assign unused_rid = ^s_rid;

   assign ar_entry = '{id: ar_id, len: ar_len};

   r_burst_tracker #(.TRK_DEPTH(TRK_DEPTH)) u_tracker (
      .w_clk   (w_clk),
      .w_rst   (w_rst),
      .push_i  (ar_fire),
      .entry_i (ar_entry),
      .pop_i   (trk_pop),
      .head_o  (trk_head),
      .empty_o (trk_empty),
      .full_o  (trk_full)
   );

   assign r_accept   = s_rvalid && s_rready_q;
   assign last_exp   = (cnt_q == '0);
   assign final_beat = s_rlast || last_exp;
   assign len_viol   = s_rlast ^ last_exp;
   assign beat_word  = pack_rword(trk_head.id, s_rdata,
                                  len_viol ? RESP_SLVERR : s_rresp, final_beat);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      beat_valid = 1'b0;
      trk_pop    = 1'b0;
      len_err_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!trk_empty) begin
               state_d = ST_BURST;
               cnt_d   = trk_head.len;
            end
         end
         ST_BURST: begin
            if (r_accept) begin
               beat_valid = 1'b1;
               len_err_d  = len_viol;
               if (final_beat) begin
                  trk_pop = 1'b1;
                  // Missing last: the slave still owes beats, which are swallowed in DRAIN.
                  state_d = (len_viol && !s_rlast) ? ST_DRAIN : ST_IDLE;
               end else begin
                  cnt_d = cnt_q - LEN_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (r_accept && s_rlast) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      out_valid_d  = out_valid_q && fifo_full;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (!out_valid_d && skid_valid_q) begin
         out_valid_d  = 1'b1;
         out_data_d   = skid_data_q;
         skid_valid_d = 1'b0;
      end
      if (beat_valid) begin
         if (!out_valid_d) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_word;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = beat_word;
         end
      end
      // Ready is registered from next state, so it drops the cycle after the skid fills.
      s_rready_d = (state_d == ST_DRAIN) || ((state_d == ST_BURST) && !skid_valid_d);
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         s_rready_q   <= 1'b0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         s_rready_q   <= s_rready_d;
         len_err_q    <= len_err_d;
      end
   end

   assign s_rready  = s_rready_q;
   assign fifo_push = out_valid_q && !fifo_full;
   assign fifo_data = out_data_q;
   assign len_err   = len_err_q;

endmodule

// File: tb/tb_r_chan_push.sv
// Directed and randomized bench for r_chan_push; expected FIFO words come from
// a per-burst model of the length-checking rules.
module tb_r_chan_push;

   logic        w_clk = 1'b0;
   logic        w_rst = 1'b1;
   logic        ar_fire = 1'b0;
   logic [3:0]  ar_id = '0, ar_len = '0;
   logic        trk_full;
   logic        s_rvalid = 1'b0;
   logic [3:0]  s_rid = '0;
   logic [31:0] s_rdata = '0;
   logic [1:0]  s_rresp = '0;
   logic        s_rlast = 1'b0;
   logic        s_rready;
   logic        fifo_push;
   logic [38:0] fifo_data;
   logic        fifo_full = 1'b0;
   logic        len_err;

   r_chan_push #(.TRK_DEPTH(2)) dut (
      .w_clk(w_clk), .w_rst(w_rst),
      .ar_fire(ar_fire), .ar_id(ar_id), .ar_len(ar_len), .trk_full(trk_full),
      .s_rvalid(s_rvalid), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rlast(s_rlast), .s_rready(s_rready),
      .fifo_push(fifo_push), .fifo_data(fifo_data), .fifo_full(fifo_full),
      .len_err(len_err)
   );

   always #5 w_clk = ~w_clk;

   int checks = 0, failures = 0;
   logic [38:0] exp_q[$], act_q[$];
   int acc_n = 0, push_n = 0, lerr_n = 0, exp_err = 0;
   int max_held = 0, rdy_bad = 0, occ = 0, cyc = 0;
   int first_acc = -1, first_push = -1, full_force = 0;
   bit full_rand = 1'b0, hold_mon = 1'b0;

   // FIFO back-pressure: forced windows or random stalls, changed just after the edge.
   always @(posedge w_clk) begin
      #1;
      if (full_force > 0) begin
         fifo_full = 1'b1;
         full_force--;
      end else begin
         fifo_full = full_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
   end

   // Monitor: each negedge describes what transfers at the next posedge.
   always @(negedge w_clk) begin
      #2;
      cyc++;
      if (hold_mon) begin
         occ = acc_n - push_n;
         if (occ > max_held) max_held = occ;
         if (occ >= 2 && s_rready === 1'b1) rdy_bad++;
      end
      if (s_rvalid && s_rready) begin
         acc_n++;
         if (first_acc < 0) first_acc = cyc;
      end
      if (fifo_push === 1'b1) begin
         act_q.push_back(fifo_data);
         push_n++;
         if (first_push < 0) first_push = cyc;
      end
      if (len_err === 1'b1) lerr_n++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ar_push(input logic [3:0] id, input logic [3:0] len);
      ar_fire = 1'b1;
      ar_id   = id;
      ar_len  = len;
      @(negedge w_clk);
      ar_fire = 1'b0;
   endtask

   task automatic drive_beat(input logic [31:0] d, input logic [1:0] r, input bit lst, output bit ok);
      ok       = 1'b0;
      s_rvalid = 1'b1;
      s_rdata  = d;
      s_rresp  = r;
      s_rlast  = lst;
      s_rid    = 4'($urandom);
      for (int t = 0; t < 100; t++) begin
         if (s_rready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge w_clk);
      end
      if (ok) @(negedge w_clk);
      s_rvalid = 1'b0;
      s_rlast  = 1'b0;
   endtask

   // Drives one slave burst of last_idx+1 beats and records the words the rules demand.
   task automatic send_burst(input logic [3:0] id, input logic [3:0] len, input int last_idx,
                             input bit rnd_resp, input int dbase, input int full_at, input bit gaps);
      bit closed = 1'b0;
      bit ok;
      for (int k = 0; k <= last_idx; k++) begin
         logic [31:0] d;
         logic [1:0]  r;
         bit          lst;
         d   = (dbase >= 0) ? 32'(dbase + k) : $urandom;
         r   = rnd_resp ? 2'($urandom) : 2'b00;
         lst = (k == last_idx);
         if (!closed) begin
            if (k < int'(len)) begin
               if (lst) begin
                  exp_q.push_back({id, d, 2'b10, 1'b1});
                  exp_err++;
                  closed = 1'b1;
               end else begin
                  exp_q.push_back({id, d, r, 1'b0});
               end
            end else begin
               exp_q.push_back({id, d, lst ? r : 2'b10, 1'b1});
               if (!lst) exp_err++;
               closed = 1'b1;
            end
         end
         if (k == full_at) full_force = 5;
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge w_clk);
         drive_beat(d, r, lst, ok);
         check("beat_accept", ok, 1);
      end
   endtask

   task automatic settle(input string tag);
      int n = 0;
      while (act_q.size() < exp_q.size() && n < 300) begin
         @(negedge w_clk);
         n++;
      end
      repeat (4) @(negedge w_clk);
      check({tag, "_count"}, act_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < act_q.size()) check($sformatf("%s_word%0d", tag, i), act_q[i], exp_q[i]);
      end
      check({tag, "_len_err"}, lerr_n, exp_err);
      check({tag, "_idle_rready"}, s_rready, 0);
      act_q.delete();
      exp_q.delete();
      lerr_n  = 0;
      exp_err = 0;
   endtask

   initial begin
      bit seen;
      int n;

      repeat (3) @(negedge w_clk);
      check("rst_rready", s_rready, 0);
      check("rst_push", fifo_push, 0);
      check("rst_data", fifo_data, 0);
      check("rst_len_err", len_err, 0);
      check("rst_trk_full", trk_full, 0);
      w_rst = 1'b0;
      @(negedge w_clk);
      check("idle_rready", s_rready, 0);
      act_q.delete();
      lerr_n = 0;

      // Basic 4-beat burst, plus accept-to-push latency.
      first_acc  = -1;
      first_push = -1;
      ar_push(4'd3, 4'd3);
      send_burst(4'd3, 4'd3, 3, 1'b0, 32'h10, -1, 1'b0);
      settle("basic");
      check("latency", first_push - first_acc, 1);

      // FIFO stalls 5 cycles inside an 8-beat burst.
      acc_n    = 0;
      push_n   = 0;
      max_held = 0;
      rdy_bad  = 0;
      hold_mon = 1'b1;
      ar_push(4'd9, 4'd7);
      send_burst(4'd9, 4'd7, 7, 1'b1, -1, 2, 1'b0);
      settle("stall");
      hold_mon = 1'b0;
      check("stall_max_held", max_held, 2);
      check("stall_rready_skid", rdy_bad, 0);

      // Early last on beat 2 of a 4-beat burst.
      ar_push(4'd5, 4'd3);
      send_burst(4'd5, 4'd3, 1, 1'b1, -1, -1, 1'b0);
      settle("early_last");

      // Missing last: 2-beat burst, slave sends 4.
      ar_push(4'd7, 4'd1);
      send_burst(4'd7, 4'd1, 3, 1'b1, -1, -1, 1'b0);
      settle("missing_last");

      // Tracker fills; a third AR is ignored.
      ar_fire = 1'b1; ar_id = 4'd1; ar_len = 4'd2;
      @(negedge w_clk);
      ar_id = 4'd2; ar_len = 4'd1;
      @(negedge w_clk);
      ar_fire = 1'b0;
      check("trk_full_two", trk_full, 1);
      ar_push(4'd5, 4'd0);
      check("trk_full_hold", trk_full, 1);
      send_burst(4'd1, 4'd2, 2, 1'b1, -1, -1, 1'b0);
      send_burst(4'd2, 4'd1, 1, 1'b1, -1, -1, 1'b0);
      settle("in_order");
      check("trk_empty_after", trk_full, 0);

      // Randomized bursts with random stalls, gaps and length violations.
      full_rand = 1'b1;
      for (int b = 0; b < 16; b++) begin
         logic [3:0] id, len;
         int mode, last_idx;
         id       = 4'($urandom);
         len      = 4'($urandom_range(0, 7));
         mode     = $urandom_range(0, 3);
         last_idx = int'(len);
         if (mode == 0 && len != 0) last_idx = $urandom_range(0, int'(len) - 1);
         if (mode == 1) last_idx = int'(len) + $urandom_range(1, 3);
         ar_push(id, len);
         send_burst(id, len, last_idx, 1'b1, -1, -1, 1'b1);
         settle($sformatf("rand%0d", b));
      end
      full_rand = 1'b0;

      // Reset mid-burst with output and skid registers both holding beats.
      full_force = 40;
      ar_push(4'd6, 4'd7);
      s_rvalid = 1'b1;
      s_rlast  = 1'b0;
      seen     = 1'b0;
      n        = 0;
      while (n < 40) begin
         if (s_rready === 1'b1) seen = 1'b1;
         else if (seen) break;
         @(negedge w_clk);
         s_rdata = $urandom;
         n++;
      end
      check("rst_mid_skid_full", seen && (n < 40), 1);
      w_rst    = 1'b1;
      s_rvalid = 1'b0;
      @(negedge w_clk);
      check("rst_mid_rready", s_rready, 0);
      check("rst_mid_push", fifo_push, 0);
      check("rst_mid_data", fifo_data, 0);
      check("rst_mid_len_err", len_err, 0);
      check("rst_mid_trk_full", trk_full, 0);
      w_rst      = 1'b0;
      full_force = 0;
      @(negedge w_clk);
      check("rst_release_push", fifo_push, 0);
      repeat (5) @(negedge w_clk);
      check("rst_no_stale", act_q.size(), 0);
      check("rst_idle", s_rready, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
